fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the opcode decoder. It holds the PC and issues requests to instruction memory over a req/ack handshake. It presents the fetched instruction, its PC and its 11-bit opcode field (bits 31:21) to the decode stage. It honours stalls from the hazard unit through a one-entry skid buffer and squashes wrong-path work on branch redirects.

Parameters:
- PC_W, 64, PC and address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded at reset; low 2 bits must be 0.

Ports:
- Clk  in  1  single clock, rising edge.
- ResetN  in  1  asynchronous reset, active-low.
- IMemReq  out  1  fetch request; held high until acknowledged.
- IMemAddr  out  PC_W  fetch address; stable while IMemReq=1.
- IMemAck  in  1  one-cycle pulse; IMemData valid the same cycle.
- IMemData  in  INSTR_W  fetched instruction.
- Stall  in  1  hazard unit: hold the IF/ID register.
- Redirect  in  1  one-cycle pulse: taken branch, CBZ or unconditional B.
- RedirectPC  in  PC_W  branch target.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- IFID_PC  out  PC_W  PC of the IF/ID instruction.
- IFID_Instr  out  INSTR_W  instruction word.
- IFID_OPCode  out  11  registered copy of IFID_Instr[31:21], for the decoder.

Behaviour:
- Reset (ResetN=0, asynchronous):
  - PC=RESET_PC; state=IDLE; skid buffer empty.
  - IMemReq=0; IMemAddr=RESET_PC.
  - IFID_Valid=0; IFID_PC, IFID_Instr and IFID_OPCode all 0.
- Reset mid-request aborts the request. Any later ack for the aborted request is ignored while state≠FETCH/DRAIN.
- States:
  - IDLE: always goes to FETCH on the next cycle.
  - FETCH: IMemReq=1, IMemAddr=PC.
  - HOLD: IMemReq=0; the skid buffer is full.
  - DRAIN: IMemReq=1 on the old address; waiting to discard a wrong-path response.
- IMemAck is legal in any cycle where IMemReq=1, including the first. Zero-wait memory therefore gives one instruction per cycle.
- FETCH, ack, no Redirect, IF/ID able to accept (Stall=0 or IFID_Valid=0):
  - IF/ID <= {1, PC, IMemData, IMemData[31:21]}; PC <= PC+4; stay in FETCH.
- FETCH, ack, Stall=1 and IFID_Valid=1:
  - Skid buffer <= {PC, IMemData}; PC <= PC+4; go to HOLD.
- HOLD:
  - IF/ID is unchanged while Stall=1.
  - First cycle with Stall=0: IF/ID <= skid contents; buffer empties; go to FETCH.
- No ack and Stall=0: IFID_Valid <= 0 (bubble); the other IF/ID fields hold.
- Stall=1: every IF/ID field holds, including IFID_Valid.
- Redirect=1 has priority over Stall and over ack. In that cycle:
  - IFID_Valid <= 0 and the skid buffer is flushed.
  - PC <= {RedirectPC[PC_W-1:2], 2'b00}; misaligned low bits are forced to 0.
- Next state after Redirect:
  - If IMemReq=1 and no ack this cycle: DRAIN, keeping IMemAddr at the old address.
  - Otherwise (ack discarded, or no request outstanding): FETCH.
- DRAIN:
  - On ack, discard the data and go to FETCH.
  - A further Redirect in DRAIN updates PC to the newest target; state stays DRAIN.
- PC+4 wraps modulo 2^PC_W; no error is signalled.
- Latency: a zero-wait ack at cycle n gives IFID_Valid=1 at cycle n+1.
- The same instruction is never presented twice. An instruction fetched before a Redirect never reaches IF/ID after it.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum {IDLE, FETCH, HOLD, DRAIN};
  - INSTR_BYTES=4;
  - OPC_HI=31 and OPC_LO=21, shared with the control decoder's opcode slice.
- One sub-module: fetch_skid_buffer.
  - One entry of {PC, Instr}.
  - Signals: load, unload, flush, full.
  - Asynchronous active-low reset.

Test Plan:
1. Reset release, zero-wait memory returning 0x8B020020 (ADD) at every address:
   - IMemAddr 0x0, 0x4, 0x8 on consecutive cycles.
   - IFID_Valid=1 from the second cycle; IFID_OPCode=0x458.
2. Ack delayed 3 cycles:
   - IMemReq and IMemAddr=0x0 stable for 4 cycles.
   - IFID_Valid=0 for 3 cycles, then IFID_PC=0x0 for exactly 1 cycle.
3. Stall high for 5 cycles with IF/ID full and an ack arriving:
   - IF/ID unchanged throughout; state HOLD; IMemReq=0.
   - Stall falls: IF/ID shows the buffered PC, then fetch resumes at buffered PC+4.
4. Redirect to 0x100 while a request to 0x20 is outstanding:
   - IFID_Valid=0 next cycle; DRAIN until the ack for 0x20; that data is discarded.
   - Next IMemAddr=0x100.
5. Redirect to 0x203 coinciding with an ack and Stall=1:
   - Flush wins; the acked data is dropped.
   - Next IMemAddr=0x200; IFID_Valid=0.
6. Starting at PC=0xFFFF_FFFF_FFFF_FFFC with an ack, then ResetN pulsed low mid-request:
   - The ack makes PC wrap to 0x0.
   - Outputs go to reset values immediately on the ResetN pulse, not at the next edge.
   - A stray ack arriving during IDLE is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    // Opcode slice, shared with the control decoder.
    localparam int OPC_HI      = 31;
    localparam int OPC_LO      = 21;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if
// Instruction-memory, hazard/redirect and IF/ID signals of the fetch stage.
// Revision: 1.0
// ============================================================================
interface fetch_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    import fetch_pkg::*;

    logic                     IMemReq;
    logic [PC_W-1:0]          IMemAddr;
    logic                     IMemAck;
    logic [INSTR_W-1:0]       IMemData;
    logic                     Stall;
    logic                     Redirect;
    logic [PC_W-1:0]          RedirectPC;
    logic                     IFID_Valid;
    logic [PC_W-1:0]          IFID_PC;
    logic [INSTR_W-1:0]       IFID_Instr;
    logic [OPC_HI-OPC_LO:0]   IFID_OPCode;

    modport master (
        output IMemReq, IMemAddr, IFID_Valid, IFID_PC, IFID_Instr, IFID_OPCode,
        input  IMemAck, IMemData, Stall, Redirect, RedirectPC
    );

    modport slave (
        input  IMemReq, IMemAddr, IFID_Valid, IFID_PC, IFID_Instr, IFID_OPCode,
        output IMemAck, IMemData, Stall, Redirect, RedirectPC
    );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// fetch_skid_buffer
// One-entry {PC, Instr} holding register used while IF/ID is stalled.
// Revision: 1.0
// ============================================================================
module fetch_skid_buffer #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  wire logic               Clk,
    input  wire logic               ResetN,
    input  wire logic               i_load,
    input  wire logic               i_unload,
    input  wire logic               i_flush,
    input  wire logic [PC_W-1:0]    i_pc,
    input  wire logic [INSTR_W-1:0] i_instr,
    output logic                    o_full,
    output logic [PC_W-1:0]         o_pc,
    output logic [INSTR_W-1:0]      o_instr
);

    logic               r_full;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_flush) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_unload) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage
// PC, instruction-memory request FSM and IF/ID pipeline register.
// Revision: 1.0
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic Clk,
    input  wire logic ResetN,
    fetch_if.master   bus
);

    fetch_state_t        r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt, r_drain_addr;
    logic                r_ifid_valid;
    logic [PC_W-1:0]     r_ifid_pc;
    logic [INSTR_W-1:0]  r_ifid_instr;
    logic [OPC_HI-OPC_LO:0] r_ifid_opc;

    logic w_req, w_can_accept;
    logic w_ifid_fetch, w_ifid_skid, w_ifid_bubble, w_ifid_flush;
    logic w_skid_load, w_skid_unload, w_skid_flush, w_drain_capture;
    logic w_skid_full;
    logic [PC_W-1:0]    w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;
    logic w_unused_ok;

    assign w_req        = (r_state == FETCH) || (r_state == DRAIN);
    assign w_can_accept = !bus.Stall || !r_ifid_valid;
    assign w_unused_ok  = &{1'b0, bus.RedirectPC[1:0], w_skid_full};

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ifid_fetch    = 1'b0;
        w_ifid_skid     = 1'b0;
        w_ifid_bubble   = 1'b0;
        w_ifid_flush    = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_unload   = 1'b0;
        w_skid_flush    = 1'b0;
        w_drain_capture = 1'b0;
        if (bus.Redirect) begin
            w_ifid_flush = 1'b1;
            w_skid_flush = 1'b1;
            w_pc_nxt     = {bus.RedirectPC[PC_W-1:2], 2'b00};
            // An unanswered request must still be consumed before refetching.
            if (w_req && !bus.IMemAck) begin
                w_state_nxt     = DRAIN;
                w_drain_capture = (r_state != DRAIN);
            end else begin
                w_state_nxt = FETCH;
            end
        end else begin
            w_ifid_bubble = !bus.Stall;
            case (r_state)
                IDLE: w_state_nxt = FETCH;
                FETCH: begin
                    if (bus.IMemAck) begin
                        w_pc_nxt = r_pc + PC_W'(INSTR_BYTES);
                        if (w_can_accept) begin
                            w_ifid_fetch = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.Stall) begin
                        w_ifid_skid   = 1'b1;
                        w_skid_unload = 1'b1;
                        w_state_nxt   = FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.IMemAck) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_opc   <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_drain_capture) begin
                r_drain_addr <= r_pc;
            end
            if (w_ifid_flush) begin
                r_ifid_valid <= 1'b0;
            end else if (w_ifid_fetch) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= bus.IMemData;
                r_ifid_opc   <= bus.IMemData[OPC_HI:OPC_LO];
            end else if (w_ifid_skid) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= w_skid_pc;
                r_ifid_instr <= w_skid_instr;
                r_ifid_opc   <= w_skid_instr[OPC_HI:OPC_LO];
            end else if (w_ifid_bubble) begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

    fetch_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_skid_flush),
        .i_pc     (r_pc),
        .i_instr  (bus.IMemData),
        .o_full   (w_skid_full),
        .o_pc     (w_skid_pc),
        .o_instr  (w_skid_instr)
    );

    assign bus.IMemReq     = w_req;
    assign bus.IMemAddr    = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign bus.IFID_Valid  = r_ifid_valid;
    assign bus.IFID_PC     = r_ifid_pc;
    assign bus.IFID_Instr  = r_ifid_instr;
    assign bus.IFID_OPCode = r_ifid_opc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage
// Directed scenarios plus random traffic against a queue-based fetch model.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int          PC_W    = 64;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] ADD     = 32'h8B02_0020;

    logic Clk;
    logic ResetN;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_stage #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC ('0)
    ) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: instructions held by the stage form a queue; head is IF/ID, second is the skid entry.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    bit          m_idle, m_drain, m_req_now, m_ack_now;
    logic [63:0] m_pc, m_daddr, m_dpc, m_addr_now;
    logic [31:0] m_dinstr;

    function automatic bit m_req();
        return !m_idle && (m_drain || q.size() < 2);
    endfunction

    function automatic logic [63:0] m_addr();
        return m_drain ? m_daddr : m_pc;
    endfunction

    always @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            q.delete();
            m_idle   = 1'b1;
            m_drain  = 1'b0;
            m_pc     = '0;
            m_daddr  = '0;
            m_dpc    = '0;
            m_dinstr = '0;
        end else begin
            m_req_now  = m_req();
            m_addr_now = m_addr();
            m_ack_now  = bus.IMemAck && m_req_now;
            if (bus.Redirect) begin
                q.delete();
                if (m_req_now && !bus.IMemAck) begin
                    if (!m_drain) m_daddr = m_addr_now;
                    m_drain = 1'b1;
                end else begin
                    m_drain = 1'b0;
                end
                m_pc   = {bus.RedirectPC[63:2], 2'b00};
                m_idle = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else begin
                if (!bus.Stall && q.size() > 0) void'(q.pop_front());
                if (m_drain) begin
                    if (m_ack_now) m_drain = 1'b0;
                end else if (m_ack_now) begin
                    q.push_back('{pc: m_pc, instr: bus.IMemData});
                    m_pc = m_pc + 64'd4;
                end
            end
            if (q.size() > 0) begin
                m_dpc    = q[0].pc;
                m_dinstr = q[0].instr;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("IMemReq",     64'(bus.IMemReq),     64'(m_req()));
        chk("IMemAddr",    bus.IMemAddr,         m_addr());
        chk("IFID_Valid",  64'(bus.IFID_Valid),  64'(q.size() > 0));
        chk("IFID_PC",     bus.IFID_PC,          m_dpc);
        chk("IFID_Instr",  64'(bus.IFID_Instr),  64'(m_dinstr));
        chk("IFID_OPCode", 64'(bus.IFID_OPCode), 64'(m_dinstr[31:21]));
    endtask

    task automatic step(input bit ack, input logic [31:0] data, input bit stall,
                        input bit redir, input logic [63:0] rpc);
        bus.IMemAck    = ack;
        bus.IMemData   = data;
        bus.Stall      = stall;
        bus.Redirect   = redir;
        bus.RedirectPC = rpc;
        @(posedge Clk);
        @(negedge Clk);
        cmp_model();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   64'(bus.IMemReq),     64'd0);
        chk({tag, "_addr"},  bus.IMemAddr,         64'd0);
        chk({tag, "_valid"}, 64'(bus.IFID_Valid),  64'd0);
        chk({tag, "_pc"},    bus.IFID_PC,          64'd0);
        chk({tag, "_instr"}, 64'(bus.IFID_Instr),  64'd0);
        chk({tag, "_opc"},   64'(bus.IFID_OPCode), 64'd0);
    endtask

    task automatic do_reset();
        ResetN         = 1'b0;
        bus.IMemAck    = 1'b0;
        bus.IMemData   = '0;
        bus.Stall      = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = '0;
        repeat (2) @(negedge Clk);
        ResetN = 1'b1;
    endtask

    initial begin
        // Scenario 1: zero-wait memory
        do_reset();
        chk_reset_vals("rst");
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        chk("s1_addr0", bus.IMemAddr, 64'h0);
        chk("s1_req0", 64'(bus.IMemReq), 64'd1);
        step(1'b1, ADD, 1'b0, 1'b0, '0);
        chk("s1_addr4", bus.IMemAddr, 64'h4);
        chk("s1_valid", 64'(bus.IFID_Valid), 64'd1);
        chk("s1_opc", 64'(bus.IFID_OPCode), 64'h458);
        step(1'b1, ADD, 1'b0, 1'b0, '0);
        chk("s1_addr8", bus.IMemAddr, 64'h8);
        chk("s1_pc4", bus.IFID_PC, 64'h4);

        // Scenario 2: ack delayed three cycles
        do_reset();
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, ADD, 1'b0, 1'b0, '0);
            chk("s2_addr", bus.IMemAddr, 64'h0);
            chk("s2_req", 64'(bus.IMemReq), 64'd1);
            chk("s2_bubble", 64'(bus.IFID_Valid), 64'd0);
        end
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, '0);
        chk("s2_valid", 64'(bus.IFID_Valid), 64'd1);
        chk("s2_pc", bus.IFID_PC, 64'h0);
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        chk("s2_once", 64'(bus.IFID_Valid), 64'd0);

        // Scenario 3: stall with IF/ID full while an ack arrives
        do_reset();
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        step(1'b1, 32'hAAAA_0000, 1'b0, 1'b0, '0);
        step(1'b1, 32'hBBBB_1111, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, ADD, 1'b1, 1'b0, '0);
            chk("s3_hold_pc", bus.IFID_PC, 64'h0);
            chk("s3_hold_req", 64'(bus.IMemReq), 64'd0);
        end
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        chk("s3_skid_pc", bus.IFID_PC, 64'h4);
        chk("s3_skid_instr", 64'(bus.IFID_Instr), 64'hBBBB_1111);
        chk("s3_resume", bus.IMemAddr, 64'h8);

        // Scenario 4: redirect to 0x100 with request to 0x20 outstanding
        do_reset();
        step(1'b0, ADD, 1'b0, 1'b1, 64'h20);
        chk("s4_addr20", bus.IMemAddr, 64'h20);
        step(1'b0, ADD, 1'b0, 1'b1, 64'h100);
        chk("s4_drain_addr", bus.IMemAddr, 64'h20);
        chk("s4_drain_valid", 64'(bus.IFID_Valid), 64'd0);
        step(1'b0, ADD, 1'b0, 1'b0, '0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        chk("s4_addr100", bus.IMemAddr, 64'h100);
        chk("s4_discard", 64'(bus.IFID_Valid), 64'd0);
        step(1'b1, ADD, 1'b0, 1'b0, '0);
        chk("s4_pc100", bus.IFID_PC, 64'h100);

        // Scenario 5: misaligned redirect coinciding with ack and stall
        step(1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 64'h203);
        chk("s5_addr200", bus.IMemAddr, 64'h200);
        chk("s5_valid", 64'(bus.IFID_Valid), 64'd0);

        // Scenario 6: PC wrap, then asynchronous reset mid-request
        step(1'b1, ADD, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("s6_top", bus.IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, ADD, 1'b0, 1'b0, '0);
        chk("s6_wrap", bus.IMemAddr, 64'h0);
        chk("s6_toppc", bus.IFID_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.IMemAck = 1'b0;
        #2;
        ResetN = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge Clk);
        ResetN = 1'b1;
        step(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0);
        chk("s6_stray_valid", 64'(bus.IFID_Valid), 64'd0);
        chk("s6_stray_addr", bus.IMemAddr, 64'h0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) != 0, $urandom, ($urandom % 4) == 0,
                 ($urandom % 16) == 0, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
